// File: rtl/frv_mem_responder_pkg.sv
// Shared widths and helpers for the memory responder and its response queue.
// Module-parameter-dependent widths are derived through the functions below.
package frv_mem_responder_pkg;

  localparam int RDATA_W = 32;
  localparam int WAIT_W  = 4;

  function automatic int mem_idx_w(input int words);
    return $clog2(words);
  endfunction

  // A single-entry queue still needs a one-bit pointer.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic logic req_error(
    input logic [31:0] addr,
    input logic        wen,
    input logic        read_only,
    input logic [31:0] base,
    input logic [31:0] span_mask
  );
    logic misaligned;
    logic out_of_range;
    misaligned   = (addr[1:0] != 2'b00);
    out_of_range = ((addr & ~span_mask) != base);
    return misaligned || out_of_range || (wen && read_only);
  endfunction

endpackage

// File: rtl/frv_mem_responder_if.sv
// req/gnt/recv/ack memory channel between a core port and its responder.
interface frv_mem_responder_if;
  logic        req;
  logic        wen;
  logic [3:0]  strb;
  logic [31:0] wdata;
  logic [31:0] addr;
  logic        gnt;
  logic        recv;
  logic        ack;
  logic        error;
  logic [31:0] rdata;

  modport master (
    output req, wen, strb, wdata, addr, ack,
    input  gnt, recv, error, rdata
  );

  modport slave (
    input  req, wen, strb, wdata, addr, ack,
    output gnt, recv, error, rdata
  );
endinterface

// File: rtl/frv_mem_rsp_fifo.sv
// Circular in-order response queue; every slot counts its wait down each cycle.
// Only the head entry is visible to the consumer.
module frv_mem_rsp_fifo
  import frv_mem_responder_pkg::*;
#(
  parameter  int DEPTH  = 2,
  parameter  int DATA_W = 33,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic [WAIT_W-1:0] push_wait_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic [WAIT_W-1:0] head_wait_o
);

  localparam int PW = ptr_w(DEPTH);

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [WAIT_W-1:0] wait_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              push_ok_s;
  logic              pop_ok_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign empty_o     = (count_q == {CNT_W{1'b0}});
  assign count_o     = count_q;
  assign push_ok_s   = push_i && !full_o;
  assign pop_ok_s    = pop_i && !empty_o;
  assign head_data_o = data_q[rd_ptr_q];
  assign head_wait_o = wait_q[rd_ptr_q];

  // Queue state: pointers, occupancy, per-slot countdown and payload.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        wait_q[i] <= {WAIT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wait_q[i] != {WAIT_W{1'b0}}) begin
          wait_q[i] <= wait_q[i] - WAIT_W'(1);
        end
      end
      if (push_ok_s) begin
        data_q[wr_ptr_q] <= push_data_i;
        wait_q[wr_ptr_q] <= push_wait_i;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop_ok_s) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/frv_mem_responder.sv
// Target end of a core memory port: word SRAM with byte strobes, fixed
// response latency, in-order response queue and error signalling.
module frv_mem_responder
  import frv_mem_responder_pkg::*;
#(
  parameter logic [31:0] MEM_BASE        = 32'h8000_0000,
  parameter int          MEM_WORDS       = 1024,
  parameter int          RSP_LATENCY     = 1,
  parameter int          MAX_OUTSTANDING = 2,
  parameter bit          READ_ONLY       = 1'b0
) (
  input  logic                g_clk,
  input  logic                g_resetn,
  frv_mem_responder_if.slave  mem
);

  localparam int                IDX_W     = mem_idx_w(MEM_WORDS);
  localparam int                CNT_W     = $clog2(MAX_OUTSTANDING + 1);
  localparam int                ENTRY_W   = RDATA_W + 1;
  localparam logic [31:0]       SPAN_MASK = 32'(MEM_WORDS * 4 - 1);
  localparam logic [WAIT_W-1:0] PUSH_WAIT = WAIT_W'(RSP_LATENCY - 1);

  logic [31:0]        mem_q [MEM_WORDS];
  logic [IDX_W-1:0]   idx_s;
  logic               accept_s;
  logic               err_s;
  logic               full_s;
  logic               empty_s;
  logic               recv_s;
  logic               pop_s;
  logic [CNT_W-1:0]   unused_count_s;
  logic [ENTRY_W-1:0] push_data_s;
  logic [ENTRY_W-1:0] head_data_s;
  logic [WAIT_W-1:0]  head_wait_s;

  // Grant looks only at registered occupancy, so a same-cycle pop never frees a slot.
  assign mem.gnt  = g_resetn && !full_s;
  assign accept_s = mem.req && mem.gnt;
  assign err_s    = req_error(mem.addr, mem.wen, READ_ONLY, MEM_BASE, SPAN_MASK);
  assign idx_s    = mem.addr[IDX_W+1:2];

  // Queue entry payload {rdata, error}: only clean reads carry array data.
  always_comb begin
    push_data_s = {{RDATA_W{1'b0}}, err_s};
    if (!mem.wen && !err_s) begin
      push_data_s = {mem_q[idx_s], 1'b0};
    end else begin
      push_data_s = {{RDATA_W{1'b0}}, err_s};
    end
  end

  generate
    if (!READ_ONLY) begin : g_write
      // Byte-lane writes land at the accept edge; the array has no reset.
      always_ff @(posedge g_clk) begin
        if (accept_s && mem.wen && !err_s) begin
          for (int b = 0; b < 4; b++) begin
            if (mem.strb[b]) begin
              mem_q[idx_s][8*b +: 8] <= mem.wdata[8*b +: 8];
            end
          end
        end
      end
    end
  endgenerate

  frv_mem_rsp_fifo #(
    .DEPTH  (MAX_OUTSTANDING),
    .DATA_W (ENTRY_W)
  ) u_rsp_fifo (
    .clk_i       (g_clk),
    .rst_ni      (g_resetn),
    .push_i      (accept_s),
    .push_data_i (push_data_s),
    .push_wait_i (PUSH_WAIT),
    .pop_i       (pop_s),
    .full_o      (full_s),
    .empty_o     (empty_s),
    .count_o     (unused_count_s),
    .head_data_o (head_data_s),
    .head_wait_o (head_wait_s)
  );

  // Outputs are gated by reset so a queued response never shows while it is asserted.
  assign recv_s    = g_resetn && !empty_s && (head_wait_s == {WAIT_W{1'b0}});
  assign pop_s     = recv_s && mem.ack;
  assign mem.recv  = recv_s;
  assign mem.rdata = recv_s ? head_data_s[ENTRY_W-1:1] : {RDATA_W{1'b0}};
  assign mem.error = recv_s && head_data_s[0];

endmodule

// File: doc/frv_mem_responder.md
Name: frv_mem_responder

Overview:
- Memory-side responder for the core's req/gnt/recv/ack memory interface, i.e. the target end of imem_* or dmem_*.
- Word-addressed SRAM model with byte strobes, configurable response latency, in-order outstanding-request queue and error signalling.
- Instantiated per port in the SoC top and in the core testbench, one per imem/dmem channel.

Parameters:
- MEM_BASE, 32'h8000_0000, byte base address of the array; must be aligned to MEM_WORDS*4.
- MEM_WORDS, 1024, number of 32-bit words; power of 2, at least 4.
- RSP_LATENCY, 1, cycles from the accept edge to earliest recv; range 1..15.
- MAX_OUTSTANDING, 2, response queue depth; power of 2, range 1..8.
- READ_ONLY, 0, when set every write returns error and leaves memory unchanged (imem use).

Ports:
- g_clk  in  1  global clock.
- g_resetn  in  1  synchronous reset, active low.
- mem_req  in  1  request valid; held by the initiator until gnt.
- mem_wen  in  1  1 = write, 0 = read.
- mem_strb  in  4  byte write strobes; ignored for reads.
- mem_wdata  in  32  write data.
- mem_addr  in  32  byte address.
- mem_gnt  out  1  request accepted this cycle when mem_req && mem_gnt.
- mem_recv  out  1  response valid.
- mem_ack  in  1  initiator accepts the response this cycle when mem_recv && mem_ack.
- mem_error  out  1  response carries an error; qualified by mem_recv.
- mem_rdata  out  32  read data; qualified by mem_recv.

Behaviour:
- Reset: during reset and in the first cycle after it, mem_recv=0, mem_error=0, mem_rdata=0 and mem_gnt=0 (mem_gnt=0 applies only while g_resetn=0). Reset empties the queue and clears all latency counters. Memory contents are not reset.
- Reset mid-operation: all outstanding responses are discarded. Writes accepted before the reset edge remain in memory.
- Grant: mem_gnt = g_resetn && (count != MAX_OUTSTANDING), computed from registered state only. There is no bypass; a pop in the same cycle does not free a slot until the next cycle.
- Accept (mem_req && mem_gnt at a rising edge):
  - Error is set if any of these holds: mem_addr[1:0] != 0; mem_addr outside [MEM_BASE, MEM_BASE + MEM_WORDS*4); mem_wen && READ_ONLY.
  - Word index = mem_addr[log2(MEM_WORDS)+1:2].
  - Write without error: at the same edge, each byte lane i with mem_strb[i]=1 is updated.
  - Read without error: the array word is captured into the queue entry at the accept edge.
  - Read with error: entry rdata = 0. Write responses always carry rdata = 0.
  - Each pushed entry holds {rdata[31:0], error, wait[3:0]}, with wait = RSP_LATENCY-1.
- Ordering: requests accepted in cycle N are ordered before those accepted in N+1. A read following a write to the same word returns the new data.
- Wait counters: every queued entry with wait != 0 decrements by 1 each cycle, whether or not it is at the head.
- Response:
  - mem_recv = queue non-empty && head.wait == 0. mem_rdata and mem_error are driven from the head entry.
  - Once mem_recv is asserted, it stays asserted and mem_rdata/mem_error stay stable until mem_recv && mem_ack.
  - Pop on mem_recv && mem_ack. The next entry may assert mem_recv in the following cycle if its wait is 0.
  - mem_ack while mem_recv=0 is ignored.
- Latency: accept edge at the end of cycle N means earliest mem_recv in cycle N+RSP_LATENCY. With RSP_LATENCY=1, MAX_OUTSTANDING=2 and ack held high, sustained throughput is 1 request/cycle.
- Simultaneous push and pop: both occur, count is unchanged, and pointers wrap modulo MAX_OUTSTANDING.
- Full: mem_gnt=0. The initiator holds mem_req with its address and data stable, and the block performs no side effects.
- X-safety: mem_wen, mem_strb, mem_addr and mem_wdata are don't-care while mem_req=0.

Decomposition:
- Shared header alongside the common core header holds:
  - localparams for entry field widths (RDATA_W=32, WAIT_W=4);
  - MEM_IDX_W = clog2(MEM_WORDS) and PTR_W = clog2(MAX_OUTSTANDING);
  - the error-cause predicate as a function.
- Sub-module frv_mem_rsp_fifo: parameterised depth/width circular queue with push, pop, full, empty, count and per-entry wait countdown. It exposes the head entry only.
- The top level contains the array, the address decode and the grant logic.

Test Plan:
- Write then read, default parameters: write 0x8000_0010 with data 0xDEAD_BEEF and strb 4'b1111, then read the same address. Required: read mem_recv one cycle after its accept, rdata 0xDEAD_BEEF, error 0.
- Byte strobe: after the word above, write strb 4'b0010 with data 0x0000_5500. Required: read returns 0xDEAD_55EF.
- Errors:
  - read 0x8000_0002 -> error=1, rdata=0;
  - read 0x0000_0000 -> error=1;
  - READ_ONLY=1 write to 0x8000_0000 -> error=1, and a later read shows the old value.
- Backpressure, MAX_OUTSTANDING=2: three back-to-back reads with ack held low. Required: two grants, then mem_gnt=0. After one ack, mem_gnt=1 on the following cycle and the third read is granted. Responses come back in order with rdata stable while waiting for ack.
- Latency, RSP_LATENCY=4: read accepted in cycle 10 -> mem_recv first high in cycle 14. Back-to-back reads with ack=1 -> recv in cycles 14 and 15.
- Reset mid-flight: two reads queued, then g_resetn=0 for one cycle. Required: mem_recv=0, mem_gnt=0 during reset and mem_gnt=1 after it, no stale response ever appears, and earlier written data is still present.
